commit_checker: RTL and testbench
=================================

# commit_checker

Hardware lockstep comparator that consumes two retire streams in the processor verification environment: one from the pipelined DUT core and one from the golden single-cycle reference core. Each stream is buffered in its own FIFO, and commits are compared in program order. The block flags any field mismatch and keeps match and mismatch counts. It halts the comparison on error or on excessive lag, so the bench monitor samples a pass/fail verdict instead of diffing full register and RAM images.

## Interface
- DATA_WIDTH, 32, width of pc, instruction and write-data fields
- FIFO_DEPTH, 8, entries per commit FIFO; power of two, minimum 2
- TIMEOUT, 64, cycles one side may lead while the other FIFO is empty
- STOP_ON_ERR, 1, 1 = enter HALT on first mismatch; 0 = count and continue
- CLK  in  1  clock, all state updates on rising edge
- RESET_N  in  1  asynchronous, active-low reset
- clear  in  1  synchronous: flushes FIFOs, zeroes counters and flags, returns to RUN
- dut_valid / gold_valid  in  1  commit strobe from each core
- dut_ready / gold_ready  out  1  = !fifo_full && state==RUN (combinational)
- dut_pc, gold_pc  in  DATA_WIDTH  pc of the retired instruction
- dut_instr, gold_instr  in  DATA_WIDTH  retired instruction word
- dut_rd, gold_rd  in  5  destination register index
- dut_wdata, gold_wdata  in  DATA_WIDTH  value written to rd
- mismatch  out  1  one-cycle pulse per failing compare
- mismatch_field  out  4  bit0 pc, bit1 instr, bit2 rd, bit3 wdata; held from the last failing compare
- mismatch_pc  out  DATA_WIDTH  gold_pc of the last failing compare
- match_count  out  32  passing compares; wraps
- mismatch_count  out  16  failing compares; saturates at 0xFFFF
- timeout  out  1  sticky lag-timeout flag
- halted  out  1  state==HALT

## Operation
- Push: a FIFO accepts an entry when valid && ready. Valid while ready is low is dropped; the producer must hold.
- States: RUN and HALT.
  - RUN to HALT occurs on a failing compare when STOP_ON_ERR=1, or on timeout.
  - HALT to RUN occurs only on clear.
  - In HALT there are no pushes or pops, and FIFO contents are frozen.
- Compare: in RUN, when both FIFOs are non-empty, both heads pop in the same cycle and are compared field by field.
- rd rule: the rd field is always compared. wdata is compared only when gold_rd != 0; x0 writes are ignored.
- Result of a compare:
  - Pass: match_count increments by 1.
  - Fail: mismatch pulses, mismatch_field and mismatch_pc load, and mismatch_count increments (saturating).
- Lag counter:
  - Increments each RUN cycle in which exactly one FIFO is non-empty and no pop occurs.
  - Clears on any pop, or when both FIFOs are empty.
  - When it reaches TIMEOUT-1 and would increment, timeout sets and the state moves to HALT.
- clear has priority over push, pop and compare in the same cycle. RESET_N has priority over everything.

## Timing
- Reset (asynchronous assert, synchronous-release assumed by the system):
  - State RUN, FIFOs empty, lag counter 0.
  - All flags, counts, mismatch_field and mismatch_pc are 0.
  - dut_ready and gold_ready read 1.
- FIFO write in cycle N; the entry is poppable in cycle N+1. There is no bypass.
- Pop/compare in cycle N; mismatch, counters and the state change are visible after edge N+1.
- End-to-end latency: both valids in cycle 0 with empty FIFOs gives a compare in cycle 1 and the result in cycle 2.
- Full FIFO: ready is low even if a pop occurs in the same cycle, so simultaneous push+pop on a full FIFO never happens.
- Push and pop on a non-full FIFO in the same cycle are both honoured, and the occupancy is unchanged.
- Reset mid-operation discards all buffered commits. clear mid-HALT discards entries and rearms.

## Test plan
- Identical streams: 20 commits (pc 0x0, 0x4, …) driven on both sides in the same cycles -> match_count=20, mismatch_count=0, never halted.
- DUT lags by 5 cycles, 8 commits, FIFO_DEPTH=8 -> gold_ready never drops, all 8 match, timeout=0.
- wdata error: 3rd commit has dut_wdata=0xDEADBEEF vs gold 0x00000005, rd=3, STOP_ON_ERR=1 -> mismatch pulses once, mismatch_field=4'b1000, mismatch_pc=0x8, halted=1, dut_ready=gold_ready=0, match_count=2.
- rd=0 with differing wdata on both sides -> counted as a match; rd 0 vs 1 -> mismatch_field=4'b0100.
- Gold pushes 9 commits, DUT silent, FIFO_DEPTH=8 -> gold_ready low after 8 pushes; timeout=1 and halted=1 once the lag counter reaches TIMEOUT; clear -> all zero, both ready=1.
- STOP_ON_ERR=0 with every commit wrong for 70000 compares -> mismatch_count holds at 0xFFFF and halted stays 0.

Source files
------------

// File: rtl/commit_checker.sv
// rtl/commit_checker.sv - lockstep retire-stream comparator for DUT vs golden core
// Two commit FIFOs, in-order field compare, match/mismatch counts, lag timeout and halt.
module commit_checker #(
  parameter int DATA_WIDTH  = 32,
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT     = 64,
  parameter int STOP_ON_ERR = 1
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  clear,
  input  logic                  dut_valid,
  input  logic                  gold_valid,
  output logic                  dut_ready,
  output logic                  gold_ready,
  input  logic [DATA_WIDTH-1:0] dut_pc,
  input  logic [DATA_WIDTH-1:0] gold_pc,
  input  logic [DATA_WIDTH-1:0] dut_instr,
  input  logic [DATA_WIDTH-1:0] gold_instr,
  input  logic [4:0]            dut_rd,
  input  logic [4:0]            gold_rd,
  input  logic [DATA_WIDTH-1:0] dut_wdata,
  input  logic [DATA_WIDTH-1:0] gold_wdata,
  output logic                  mismatch,
  output logic [3:0]            mismatch_field,
  output logic [DATA_WIDTH-1:0] mismatch_pc,
  output logic [31:0]           match_count,
  output logic [15:0]           mismatch_count,
  output logic                  timeout,
  output logic                  halted
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(TIMEOUT) + 1;

  typedef enum logic {RUN, HALT} state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] instr;
    logic [4:0]            rd;
    logic [DATA_WIDTH-1:0] wdata;
  } commit_t;

  commit_t dut_mem  [FIFO_DEPTH];
  commit_t gold_mem [FIFO_DEPTH];

  state_t                state_q;
  logic [AW:0]           dwp_q, drp_q, gwp_q, grp_q;
  logic [LW-1:0]         lag_q;
  logic                  mismatch_q;
  logic [3:0]            field_q;
  logic [DATA_WIDTH-1:0] mpc_q;
  logic [31:0]           match_q;
  logic [15:0]           mcount_q;
  logic                  timeout_q;

  logic    run, d_empty, g_empty, d_full, g_full;
  logic    dut_push, gold_push, pop, fail, one_side;
  logic [3:0] cmp_field;
  commit_t dh, gh;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign run     = (state_q == RUN);
  assign d_empty = (dwp_q == drp_q);
  assign g_empty = (gwp_q == grp_q);
  assign d_full  = (dwp_q[AW] != drp_q[AW]) && (dwp_q[AW-1:0] == drp_q[AW-1:0]);
  assign g_full  = (gwp_q[AW] != grp_q[AW]) && (gwp_q[AW-1:0] == grp_q[AW-1:0]);

  assign dut_ready  = !d_full && run;
  assign gold_ready = !g_full && run;
  assign dut_push   = dut_valid && dut_ready;
  assign gold_push  = gold_valid && gold_ready;

  assign dh = dut_mem[drp_q[AW-1:0]];
  assign gh = gold_mem[grp_q[AW-1:0]];

  // Writes to x0 are architecturally invisible, so wdata only matters for a real rd.
  assign cmp_field = {(gh.rd != 5'd0) && (dh.wdata != gh.wdata),
                      dh.rd != gh.rd,
                      dh.instr != gh.instr,
                      dh.pc != gh.pc};

  assign pop      = run && !d_empty && !g_empty;
  assign fail     = pop && (cmp_field != 4'd0);
  assign one_side = d_empty ^ g_empty;

  always_ff @(posedge CLK) begin
    if (dut_push)  dut_mem[dwp_q[AW-1:0]]   <= '{dut_pc, dut_instr, dut_rd, dut_wdata};
    if (gold_push) gold_mem[gwp_q[AW-1:0]]  <= '{gold_pc, gold_instr, gold_rd, gold_wdata};
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= RUN;
      dwp_q      <= '0;
      drp_q      <= '0;
      gwp_q      <= '0;
      grp_q      <= '0;
      lag_q      <= '0;
      mismatch_q <= 1'b0;
      field_q    <= '0;
      mpc_q      <= '0;
      match_q    <= '0;
      mcount_q   <= '0;
      timeout_q  <= 1'b0;
    end else if (clear) begin
      state_q    <= RUN;
      dwp_q      <= '0;
      drp_q      <= '0;
      gwp_q      <= '0;
      grp_q      <= '0;
      lag_q      <= '0;
      mismatch_q <= 1'b0;
      field_q    <= '0;
      mpc_q      <= '0;
      match_q    <= '0;
      mcount_q   <= '0;
      timeout_q  <= 1'b0;
    end else begin
      mismatch_q <= fail;
      if (dut_push)  dwp_q <= dwp_q + 1'b1;
      if (gold_push) gwp_q <= gwp_q + 1'b1;
      if (pop) begin
        drp_q <= drp_q + 1'b1;
        grp_q <= grp_q + 1'b1;
        if (fail) begin
          field_q <= cmp_field;
          mpc_q   <= gh.pc;
          if (mcount_q != 16'hFFFF) mcount_q <= mcount_q + 16'd1;
          if (STOP_ON_ERR != 0) state_q <= HALT;
        end else begin
          match_q <= match_q + 32'd1;
        end
      end
      if (run) begin
        if (one_side) begin
          if (lag_q == LW'(TIMEOUT - 1)) begin
            timeout_q <= 1'b1;
            state_q   <= HALT;
          end else begin
            lag_q <= lag_q + 1'b1;
          end
        end else begin
          lag_q <= '0;
        end
      end
    end
  end

  assign mismatch       = mismatch_q;
  assign mismatch_field = field_q;
  assign mismatch_pc    = mpc_q;
  assign match_count    = match_q;
  assign mismatch_count = mcount_q;
  assign timeout        = timeout_q;
  assign halted         = (state_q == HALT);

endmodule

// File: tb/tb_commit_checker.sv
// tb/tb_commit_checker.sv - directed bench for commit_checker
// Drives one stimulus into a STOP_ON_ERR=1 instance (s_*) and a STOP_ON_ERR=0 instance (n_*).
module tb_commit_checker;

  logic clk = 1'b0;
  logic rst_n, clear, dut_valid, gold_valid;
  logic [31:0] dut_pc, gold_pc, dut_instr, gold_instr, dut_wdata, gold_wdata;
  logic [4:0]  dut_rd, gold_rd;

  logic s_dut_ready, s_gold_ready, s_mismatch, s_timeout, s_halted;
  logic [3:0] s_field;
  logic [31:0] s_pc, s_match;
  logic [15:0] s_mcount;
  logic n_dut_ready, n_gold_ready, n_mismatch, n_timeout, n_halted;
  logic [3:0] n_field;
  logic [31:0] n_pc, n_match;
  logic [15:0] n_mcount;

  int checks = 0;
  int failures = 0;
  int pulses_s = 0;
  int pulses_n = 0;

  always #5 clk = ~clk;

  commit_checker #(.DATA_WIDTH(32), .FIFO_DEPTH(8), .TIMEOUT(64), .STOP_ON_ERR(1)) u_st (
    .CLK(clk), .RESET_N(rst_n), .clear(clear),
    .dut_valid(dut_valid), .gold_valid(gold_valid),
    .dut_ready(s_dut_ready), .gold_ready(s_gold_ready),
    .dut_pc(dut_pc), .gold_pc(gold_pc), .dut_instr(dut_instr), .gold_instr(gold_instr),
    .dut_rd(dut_rd), .gold_rd(gold_rd), .dut_wdata(dut_wdata), .gold_wdata(gold_wdata),
    .mismatch(s_mismatch), .mismatch_field(s_field), .mismatch_pc(s_pc),
    .match_count(s_match), .mismatch_count(s_mcount), .timeout(s_timeout), .halted(s_halted)
  );

  commit_checker #(.DATA_WIDTH(32), .FIFO_DEPTH(8), .TIMEOUT(64), .STOP_ON_ERR(0)) u_nc (
    .CLK(clk), .RESET_N(rst_n), .clear(clear),
    .dut_valid(dut_valid), .gold_valid(gold_valid),
    .dut_ready(n_dut_ready), .gold_ready(n_gold_ready),
    .dut_pc(dut_pc), .gold_pc(gold_pc), .dut_instr(dut_instr), .gold_instr(gold_instr),
    .dut_rd(dut_rd), .gold_rd(gold_rd), .dut_wdata(dut_wdata), .gold_wdata(gold_wdata),
    .mismatch(n_mismatch), .mismatch_field(n_field), .mismatch_pc(n_pc),
    .match_count(n_match), .mismatch_count(n_mcount), .timeout(n_timeout), .halted(n_halted)
  );

  typedef struct {
    logic [31:0] dpc, dinstr;
    logic [4:0]  drd;
    logic [31:0] dwdata, gpc, ginstr;
    logic [4:0]  grd;
    logic [31:0] gwdata;
    logic [3:0]  field;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    pulses_s += int'(s_mismatch);
    pulses_n += int'(n_mismatch);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic set_d(input logic [31:0] pc, input logic [31:0] ins, input logic [4:0] rd, input logic [31:0] wd);
    dut_pc = pc; dut_instr = ins; dut_rd = rd; dut_wdata = wd;
  endtask

  task automatic set_g(input logic [31:0] pc, input logic [31:0] ins, input logic [4:0] rd, input logic [31:0] wd);
    gold_pc = pc; gold_instr = ins; gold_rd = rd; gold_wdata = wd;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, acc;
    logic flag, f;

    vecs[0] = '{32'h00, 32'h13, 5'd3, 32'h5, 32'h00, 32'h13, 5'd3, 32'h5, 4'b0000};
    vecs[1] = '{32'h10, 32'h13, 5'd3, 32'h5, 32'h14, 32'h13, 5'd3, 32'h5, 4'b0001};
    vecs[2] = '{32'h20, 32'h33, 5'd4, 32'h9, 32'h20, 32'h13, 5'd4, 32'h9, 4'b0010};
    vecs[3] = '{32'h30, 32'h13, 5'd0, 32'h7, 32'h30, 32'h13, 5'd1, 32'h7, 4'b0100};
    vecs[4] = '{32'h40, 32'h13, 5'd0, 32'h1, 32'h40, 32'h13, 5'd0, 32'h2, 4'b0000};
    vecs[5] = '{32'h50, 32'h13, 5'd3, 32'hDEADBEEF, 32'h50, 32'h13, 5'd3, 32'h5, 4'b1000};
    vecs[6] = '{32'h60, 32'h13, 5'd1, 32'h1, 32'h60, 32'h13, 5'd0, 32'h2, 4'b0100};
    vecs[7] = '{32'h04, 32'h01, 5'd2, 32'h3, 32'h08, 32'h05, 5'd6, 32'h9, 4'b1111};

    rst_n = 1'b0; clear = 1'b0; dut_valid = 1'b0; gold_valid = 1'b0;
    set_d(0, 0, 0, 0);
    set_g(0, 0, 0, 0);
    step(); step();
    rst_n = 1'b1;
    step();
    chk("rst_dut_ready", s_dut_ready, 1);
    chk("rst_gold_ready", s_gold_ready, 1);
    chk("rst_halted", s_halted, 0);
    chk("rst_match", s_match, 0);
    chk("rst_mcount", s_mcount, 0);
    chk("rst_field", s_field, 0);
    chk("rst_pc", s_pc, 0);
    chk("rst_timeout", s_timeout, 0);
    chk("rst_mismatch", s_mismatch, 0);

    // Table: one commit per vector from a cleared state.
    for (int i = 0; i < 8; i++) begin
      do_clear();
      f = (vecs[i].field != 4'd0);
      set_d(vecs[i].dpc, vecs[i].dinstr, vecs[i].drd, vecs[i].dwdata);
      set_g(vecs[i].gpc, vecs[i].ginstr, vecs[i].grd, vecs[i].gwdata);
      dut_valid = 1'b1; gold_valid = 1'b1;
      step();
      dut_valid = 1'b0; gold_valid = 1'b0;
      chk($sformatf("v%0d_no_bypass_match", i), n_match, 0);
      chk($sformatf("v%0d_no_bypass_mis", i), n_mismatch, 0);
      step();
      chk($sformatf("v%0d_mismatch", i), n_mismatch, f);
      chk($sformatf("v%0d_field", i), n_field, vecs[i].field);
      chk($sformatf("v%0d_pc", i), n_pc, f ? vecs[i].gpc : 32'h0);
      chk($sformatf("v%0d_match", i), n_match, f ? 0 : 1);
      chk($sformatf("v%0d_mcount", i), n_mcount, f);
      chk($sformatf("v%0d_s_halted", i), s_halted, f);
      chk($sformatf("v%0d_s_dut_ready", i), s_dut_ready, !f);
      step();
      chk($sformatf("v%0d_pulse_end", i), n_mismatch, 0);
    end

    // Identical streams, 20 commits.
    do_clear();
    pulses_s = 0;
    flag = 1'b1;
    for (int i = 0; i < 20; i++) begin
      set_d(4 * i, 32'h13 + i, 5'(i), 3 * i);
      set_g(4 * i, 32'h13 + i, 5'(i), 3 * i);
      dut_valid = 1'b1; gold_valid = 1'b1;
      if (!s_dut_ready || !s_gold_ready) flag = 1'b0;
      step();
    end
    dut_valid = 1'b0; gold_valid = 1'b0;
    step(); step();
    chk("ident_ready", flag, 1);
    chk("ident_match", s_match, 20);
    chk("ident_mcount", s_mcount, 0);
    chk("ident_halted", s_halted, 0);
    chk("ident_pulses", pulses_s, 0);

    // DUT lags gold by 5 cycles.
    do_clear();
    flag = 1'b1;
    for (int t = 0; t < 15; t++) begin
      gold_valid = (t < 8);
      dut_valid  = (t >= 5) && (t < 13);
      set_g(4 * t, 32'h100 + t, 5'd7, t);
      set_d(4 * (t - 5), 32'h100 + (t - 5), 5'd7, t - 5);
      if (!s_gold_ready) flag = 1'b0;
      step();
    end
    dut_valid = 1'b0; gold_valid = 1'b0;
    step(); step(); step();
    chk("lag_gold_ready", flag, 1);
    chk("lag_match", s_match, 8);
    chk("lag_mcount", s_mcount, 0);
    chk("lag_timeout", s_timeout, 0);

    // wdata error on the third commit.
    do_clear();
    pulses_s = 0;
    for (int i = 0; i < 3; i++) begin
      set_g(4 * i, 32'h13, 5'd3, 32'h5);
      set_d(4 * i, 32'h13, 5'd3, (i == 2) ? 32'hDEADBEEF : 32'h5);
      dut_valid = 1'b1; gold_valid = 1'b1;
      step();
    end
    dut_valid = 1'b0; gold_valid = 1'b0;
    step(); step(); step();
    chk("werr_pulses", pulses_s, 1);
    chk("werr_field", s_field, 4'b1000);
    chk("werr_pc", s_pc, 32'h8);
    chk("werr_halted", s_halted, 1);
    chk("werr_dut_ready", s_dut_ready, 0);
    chk("werr_gold_ready", s_gold_ready, 0);
    chk("werr_match", s_match, 2);
    chk("werr_mcount", s_mcount, 1);
    chk("werr_nc_halted", n_halted, 0);
    chk("werr_nc_match", n_match, 2);

    // Gold-only stream: FIFO fills, then lag timeout.
    do_clear();
    n = 0; acc = 0;
    for (int t = 0; t < 9; t++) begin
      set_g(32'h40 + 4 * t, 32'h13, 5'd1, t);
      gold_valid = 1'b1;
      if (t == 7) chk("to_ready_before_full", s_gold_ready, 1);
      if (t == 8) chk("to_ready_full", s_gold_ready, 0);
      acc += int'(s_gold_ready);
      step();
      n++;
    end
    gold_valid = 1'b0;
    chk("to_accepted", acc, 8);
    chk("to_early_timeout", s_timeout, 0);
    while (!s_halted && n < 200) begin
      step();
      n++;
    end
    chk("to_halt_cycle", n, 65);
    chk("to_timeout", s_timeout, 1);
    chk("to_halted", s_halted, 1);
    chk("to_nc_timeout", n_timeout, 1);
    chk("to_nc_halted", n_halted, 1);
    do_clear();
    chk("clr_match", s_match, 0);
    chk("clr_mcount", s_mcount, 0);
    chk("clr_field", s_field, 0);
    chk("clr_pc", s_pc, 0);
    chk("clr_timeout", s_timeout, 0);
    chk("clr_halted", s_halted, 0);
    chk("clr_dut_ready", s_dut_ready, 1);
    chk("clr_gold_ready", s_gold_ready, 1);
    set_d(32'h100, 32'h13, 5'd2, 32'h11);
    set_g(32'h100, 32'h13, 5'd2, 32'h11);
    dut_valid = 1'b1; gold_valid = 1'b1;
    step();
    dut_valid = 1'b0; gold_valid = 1'b0;
    step(); step();
    chk("clr_flush_match", s_match, 1);
    chk("clr_flush_mcount", s_mcount, 0);

    // Reset mid-operation discards buffered gold entries.
    for (int t = 0; t < 3; t++) begin
      set_g(32'h300 + 4 * t, 32'h13, 5'd2, 32'h1);
      gold_valid = 1'b1;
      step();
    end
    gold_valid = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    set_d(32'h200, 32'h13, 5'd2, 32'h11);
    set_g(32'h200, 32'h13, 5'd2, 32'h11);
    dut_valid = 1'b1; gold_valid = 1'b1;
    step();
    dut_valid = 1'b0; gold_valid = 1'b0;
    step(); step();
    chk("rst_flush_match", s_match, 1);
    chk("rst_flush_mcount", s_mcount, 0);

    // Continuous errors: saturation on the non-stopping instance.
    do_clear();
    set_d(32'h1, 32'h13, 5'd1, 32'h1);
    set_g(32'h2, 32'h13, 5'd1, 32'h1);
    dut_valid = 1'b1; gold_valid = 1'b1;
    for (int i = 0; i < 100; i++) step();
    dut_valid = 1'b0; gold_valid = 1'b0;
    step(); step();
    chk("sat_mcount_100", n_mcount, 100);
    chk("sat_s_mcount", s_mcount, 1);
    chk("sat_s_halted", s_halted, 1);
    dut_valid = 1'b1; gold_valid = 1'b1;
    for (int i = 0; i < 70000; i++) step();
    dut_valid = 1'b0; gold_valid = 1'b0;
    step(); step(); step();
    chk("sat_mcount", n_mcount, 16'hFFFF);
    chk("sat_halted", n_halted, 0);
    chk("sat_match", n_match, 0);
    chk("sat_field", n_field, 4'b0001);
    chk("sat_pc", n_pc, 32'h2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
